conv_out_wr_dma: RTL and testbench

//  Write-back DMA after the conv/BN/ReLU output stage. Takes one pixel word per beat (Tout lanes of
//  MAX_DAT_DW, one output pixel for one channel slice), buffers the words in a FIFO and writes them to DDR.

---
 rtl/conv_out_wr_dma.sv | 211 +++++++++++++++++++++
 tb/tb_conv_out_wr_dma.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_wr_dma.sv
// Output write-back DMA: FIFO-buffers pixel words and writes them to DDR as AXI4 INCR bursts.
// Optional macro WR_DMA_PERF_CNT_EN adds the perf_cnt busy-cycle counter output.
module conv_out_wr_dma #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  input  logic [31:0]             surface_stride,
  input  logic [31:0]             line_stride,
  input  logic [15:0]             wout,
  input  logic [15:0]             hout,
  input  logic [15:0]             ch_slices,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_WIDTH-1:0]   pix_data,
  output logic                    busy,
  output logic                    done,
  output logic                    bresp_err,
`ifdef WR_DMA_PERF_CNT_EN
  output logic [31:0]             perf_cnt,
`endif
  output logic [1:0]              fsm_state,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [31:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int OW  = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [15:0]   wout_q, hout_q, col, row;
  logic [31:0]   line_q, surf_q, slice_addr, row_addr;
  logic [47:0]   total_q, sent, in_cnt;
  logic [OW-1:0] outst;
  logic [8:0]    blen, beat;
  logic [16:0]   row_left, to_4k, burst_len;
  logic          push, pop, aw_hs, b_hs;

  // Every channel transfers on a cycle where valid and ready are both high; a valid, once
  // raised by this block, stays high with stable payload until its ready arrives.
  assign push = pix_valid & pix_ready;
  assign pop  = m_axi_wvalid & m_axi_wready;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign b_hs = m_axi_bvalid & m_axi_bready;

  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign pix_ready = busy && (count != (PW+1)'(FIFO_DEPTH)) && (in_cnt != total_q);

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awaddr  = row_addr + ({16'b0, col} << SZ);
  assign m_axi_awlen   = burst_len[7:0] - 8'd1;
  assign m_axi_wdata   = mem[rd_ptr];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state == DATA) && (beat == blen - 9'd1);
  assign m_axi_bready  = busy;

  // Burst length: capped by MAX_BURST, the end of the current row and the next 4KB page.
  always_comb begin
    row_left  = {1'b0, wout_q} - {1'b0, col};
    to_4k     = {4'b0, (13'h1000 - {1'b0, m_axi_awaddr[11:0]}) >> SZ};
    burst_len = 17'(MAX_BURST);
    if (row_left < burst_len) burst_len = row_left;
    if (to_4k < burst_len) burst_len = to_4k;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_comb begin
    state_n       = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: if (start) state_n = ADDR;
      ADDR: begin
        m_axi_awvalid = ({{(16-PW){1'b0}}, count} >= burst_len) && (outst < OW'(MAX_OUTST));
        if (m_axi_awvalid && m_axi_awready) state_n = DATA;
      end
      DATA: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && m_axi_wlast)
          state_n = (sent + {39'b0, blen} == total_q) ? DRAIN : ADDR;
      end
      DRAIN: begin
        if (outst == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wout_q     <= '0;
      hout_q     <= '0;
      line_q     <= '0;
      surf_q     <= '0;
      total_q    <= '0;
      slice_addr <= '0;
      row_addr   <= '0;
      col        <= '0;
      row        <= '0;
      sent       <= '0;
      in_cnt     <= '0;
      outst      <= '0;
      blen       <= '0;
      beat       <= '0;
      bresp_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (push) in_cnt <= in_cnt + 48'd1;
      if (aw_hs && !b_hs) outst <= outst + 1'b1;
      else if (!aw_hs && b_hs) outst <= outst - 1'b1;
      if (b_hs && m_axi_bresp != 2'b00) bresp_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          wout_q     <= wout;
          hout_q     <= hout;
          line_q     <= line_stride;
          surf_q     <= surface_stride;
          total_q    <= 48'(wout) * 48'(hout) * 48'(ch_slices);
          slice_addr <= base_addr;
          row_addr   <= base_addr;
          col        <= '0;
          row        <= '0;
          sent       <= '0;
          in_cnt     <= '0;
          outst      <= '0;
          bresp_err  <= 1'b0;
        end
        ADDR: if (aw_hs) begin
          blen <= burst_len[8:0];
          beat <= '0;
        end
        DATA: if (pop) begin
          beat <= beat + 9'd1;
          if (m_axi_wlast) begin
            sent <= sent + {39'b0, blen};
            if (col + {7'b0, blen} == wout_q) begin
              col <= '0;
              if (row == hout_q - 16'd1) begin
                row        <= '0;
                slice_addr <= slice_addr + surf_q;
                row_addr   <= slice_addr + surf_q;
              end else begin
                row      <= row + 16'd1;
                row_addr <= row_addr + line_q;
              end
            end else begin
              col <= col + {7'b0, blen};
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WR_DMA_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_cnt <= '0;
    else if (state == IDLE && start) perf_cnt <= '0;
    else if (busy) perf_cnt <= perf_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_conv_out_wr_dma.sv
// Bench for conv_out_wr_dma: random AXI slave with stalls, address-layout model and data scoreboard.
module tb_conv_out_wr_dma;
  localparam int DW  = 256;
  localparam int BPB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] base_addr = '0, surface_stride = '0, line_stride = '0;
  logic [15:0] wout = 16'd1, hout = 16'd1, ch_slices = 16'd1;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [DW-1:0] pix_data = '0;
  logic busy, done, bresp_err;
  logic [1:0] fsm_state;
  logic [3:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid;
  logic awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic wlast, wvalid;
  logic wready = 1'b0;
  logic [1:0] bresp = 2'b00;
  logic bvalid = 1'b0;
  logic bready;
`ifdef WR_DMA_PERF_CNT_EN
  logic [31:0] perf_cnt;
`endif

  conv_out_wr_dma dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .surface_stride(surface_stride), .line_stride(line_stride),
    .wout(wout), .hout(hout), .ch_slices(ch_slices),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .busy(busy), .done(done), .bresp_err(bresp_err),
`ifdef WR_DMA_PERF_CNT_EN
    .perf_cnt(perf_cnt),
`endif
    .fsm_state(fsm_state),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total_n = 0, bad_n = 0;
  int pix_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
  int b_hold_until = 0, err_burst = -1;
  int aw_cnt = 0, w_cnt = 0, done_cnt = 0, outst_tb = 0, max_outst = 0;
  int burst_idx = 0, pix_acc = 0, wb = 0, exp_n_aw = 0, exp_words = 0;
  logic exp_err = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [39:0]   exp_aw_q[$];
  logic [39:0]   slv_q[$];
  logic [1:0]    b_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // AXI slave, pixel source and scoreboard; decisions made mid-cycle, handshakes land on next posedge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pix_valid = 1'b0;
        awready = 1'b0;
        wready = 1'b0;
        bvalid = 1'b0;
      end else begin
        awready = ($urandom_range(99) < aw_pct);
        wready = ($urandom_range(99) < w_pct);
        bvalid = (b_q.size() > 0) && (cyc >= b_hold_until) && ($urandom_range(99) < b_pct);
        bresp = (b_q.size() > 0) ? b_q[0] : 2'b00;
        pix_valid = ($urandom_range(99) < pix_pct);
        for (int i = 0; i < DW / 32; i++) pix_data[i*32 +: 32] = $urandom();
        #1;
        if (pix_valid && pix_ready) begin
          exp_q.push_back(pix_data);
          pix_acc++;
        end
        if (awvalid && awready) begin
          aw_cnt++;
          outst_tb++;
          if (outst_tb > max_outst) max_outst = outst_tb;
          chk("aw_fix", DW'({awid, awsize, awburst}), DW'({4'd0, 3'd5, 2'd1}));
          if (exp_aw_q.size() == 0) chk("aw_extra", DW'(exp_aw_q.size()), DW'(1));
          else chk("aw", DW'({awaddr, awlen}), DW'(exp_aw_q.pop_front()));
          slv_q.push_back({awaddr, awlen});
        end
        if (wvalid && wready) begin
          w_cnt++;
          chk("wstrb", DW'(wstrb), DW'(32'hFFFF_FFFF));
          if (slv_q.size() == 0) chk("w_no_aw", DW'(slv_q.size()), DW'(1));
          else begin
            chk("wlast", DW'(wlast), DW'(wb == int'(slv_q[0][7:0])));
            if (exp_q.size() == 0) chk("w_nodata", DW'(exp_q.size()), DW'(1));
            else chk("wdata", wdata, exp_q.pop_front());
            if (wb == int'(slv_q[0][7:0])) begin
              void'(slv_q.pop_front());
              wb = 0;
              b_q.push_back((burst_idx == err_burst) ? 2'b10 : 2'b00);
              burst_idx++;
            end else begin
              wb++;
            end
          end
        end
        if (bvalid && bready) begin
          void'(b_q.pop_front());
          outst_tb--;
        end
        if (done) begin
          done_cnt++;
          chk("done_outst", DW'(outst_tb), DW'(0));
          chk("done_err", DW'(bresp_err), DW'(exp_err));
        end
      end
    end
  end

  // driver: build the expected AW list, then pulse start
  task automatic start_layer(input logic [31:0] b, input logic [31:0] surf, input logic [31:0] line,
                             input int w, input int h, input int c);
    exp_n_aw = 0;
    for (int s = 0; s < c; s++) begin
      for (int r = 0; r < h; r++) begin
        int col = 0;
        while (col < w) begin
          logic [31:0] a;
          int l;
          a = b + 32'(s) * surf + 32'(r) * line + 32'(col * BPB);
          l = 16;
          if (w - col < l) l = w - col;
          if ((4096 - int'(a[11:0])) / BPB < l) l = (4096 - int'(a[11:0])) / BPB;
          exp_aw_q.push_back({a, 8'(l - 1)});
          col += l;
          exp_n_aw++;
        end
      end
    end
    exp_words = w * h * c;
    exp_err = (err_burst >= 0) && (err_burst < exp_n_aw);
    aw_cnt = 0; w_cnt = 0; done_cnt = 0; burst_idx = 0; pix_acc = 0; max_outst = 0; wb = 0;
    @(negedge clk);
    base_addr = b; surface_stride = surf; line_stride = line;
    wout = 16'(w); hout = 16'(h); ch_slices = 16'(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("busy_on", DW'(busy), DW'(1));
    chk("err_clr", DW'(bresp_err), DW'(0));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (done_cnt == 0) chk("timeout", DW'(done_cnt), DW'(1));
    repeat (3) @(negedge clk);
    #2;
    chk("busy_off", DW'(busy), DW'(0));
    chk("done_once", DW'(done_cnt), DW'(1));
    chk("aw_num", DW'(aw_cnt), DW'(exp_n_aw));
    chk("w_num", DW'(w_cnt), DW'(exp_words));
    chk("pix_acc", DW'(pix_acc), DW'(exp_words));
    chk("max_outst", DW'(max_outst <= 4), DW'(1));
    chk("exp_q_empty", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic check_reset_outs();
    chk("rst_axi", DW'({awvalid, wvalid, bready}), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_ready", DW'(pix_ready), DW'(0));
    chk("rst_err", DW'(bresp_err), DW'(0));
    chk("rst_state", DW'(fsm_state), DW'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outs();
    rst = 1'b0;

    // 26x26 feature map with mild stalls
    pix_pct = 70; aw_pct = 80; w_pct = 80; b_pct = 80;
    start_layer(32'h0800_0000, 32'd21632, 32'd832, 26, 26, 1);
    wait_done(20000);

    // slice/row layout, and a 4KB split
    start_layer(32'h0, 32'h1000, 32'h200, 4, 2, 3);
    wait_done(2000);
    start_layer(32'h0FC0, 32'h0, 32'h100, 8, 1, 1);
    wait_done(1000);

    // B withheld: AW must stop at the outstanding limit
    pix_pct = 30; aw_pct = 50; w_pct = 50; b_pct = 50;
    b_hold_until = cyc + 100;
    start_layer(32'h2000_0000, 32'h1000, 32'h100, 2, 8, 2);
    repeat (92) @(negedge clk);
    #2;
    chk("aw_stop", DW'(aw_cnt), DW'(4));
    chk("outst_full", DW'(outst_tb), DW'(4));
    wait_done(5000);

    // SLVERR on 2nd burst plus a start while busy
    pix_pct = 70; aw_pct = 70; w_pct = 70; b_pct = 70;
    b_hold_until = 0; err_burst = 1;
    start_layer(32'h0100_0000, 32'h800, 32'h200, 8, 4, 2);
    repeat (20) @(negedge clk);
    base_addr = 32'h7777_0000; wout = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000);
    err_burst = -1;
    start_layer(32'h0100_0000, 32'h800, 32'h200, 4, 1, 1);
    wait_done(1000);

    // reset mid-layer, then a fresh layer
    start_layer(32'h0300_0000, 32'h4000, 32'h400, 16, 4, 1);
    n = 0;
    while (w_cnt < 10 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("w_reached", DW'(w_cnt >= 10), DW'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outs();
    exp_q.delete(); slv_q.delete(); b_q.delete(); exp_aw_q.delete();
    outst_tb = 0; wb = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_layer(32'h0300_0000, 32'h4000, 32'h400, 16, 4, 1);
    wait_done(5000);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
